// File: rtl/irq_pending_latch_if.sv
// Bus between the interrupt source/consumer side and irq_pending_latch.
// The master side drives requests, mask, encoder code and handshakes; the slave is the latch.
interface irq_pending_latch_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend;
  logic [2:0] code;
  logic       irq;
  logic       ack;
  logic       eoi;
  logic       busy;
  logic [2:0] isr_idx;

  modport master (
    output req, mask, code, ack, eoi,
    input  pend, irq, busy, isr_idx
  );

  modport slave (
    input  req, mask, code, ack, eoi,
    output pend, irq, busy, isr_idx
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Edge-latching 8-line interrupt pending register with an IDLE/REQ/SERVICE handshake FSM.
// Define IRQ_LATCH_SYNC_EN to put a 2-flop synchronizer in front of edge detection.
module irq_pending_latch (
  input logic               clk,
  input logic               rst_n,
  irq_pending_latch_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e     state_q, state_d;
  logic [7:0] req_s;
  logic [7:0] req_q;
  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] pending_q, pending_d;
  logic [2:0] isr_idx_q, isr_idx_d;
  logic       accept;

`ifdef IRQ_LATCH_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = bus.req;
`endif

  assign rise     = req_s & ~req_q;
  assign bus.pend = pending_q & ~bus.mask;
  assign accept   = (state_q == StReq) && bus.ack && bus.pend[bus.code];

  always_comb begin
    state_d   = state_q;
    clr       = '0;
    isr_idx_d = isr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.pend) state_d = StIdle == StIdle ? StReq : StIdle;
      end
      StReq: begin
        // Masking everything away withdraws the request; latched bits are kept.
        if (~|bus.pend) begin
          state_d = StIdle;
        end else if (accept) begin
          state_d        = StService;
          clr[bus.code]  = 1'b1;
          isr_idx_d      = bus.code;
        end
      end
      StService: begin
        if (bus.eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new edge on the bit being cleared wins.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      pending_q <= '0;
      isr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_s;
      pending_q <= pending_d;
      isr_idx_q <= isr_idx_d;
    end
  end

  assign bus.irq     = (state_q == StReq);
  assign bus.busy    = (state_q == StService);
  assign bus.isr_idx = isr_idx_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch: directed scenarios plus random traffic vs a reference model.
module tb_irq_pending_latch;
`ifdef IRQ_LATCH_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif
  localparam int ModeIdle    = 0;
  localparam int ModeReq     = 1;
  localparam int ModeService = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  irq_pending_latch_if bus ();

  irq_pending_latch dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pend;
    logic       irq;
    logic       busy;
    logic [2:0] isr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: latched events, a service mode and the delayed view of req.
  bit [7:0] m_latched;
  int       m_mode;
  bit [7:0] m_prev;
  bit [2:0] m_isr;
  bit [7:0] m_dly[$];

  function automatic void model_reset();
    m_latched = 8'h00;
    m_mode    = ModeIdle;
    m_prev    = 8'h00;
    m_isr     = 3'd0;
    m_dly.delete();
    for (int i = 0; i < Lat; i++) m_dly.push_back(8'h00);
  endfunction

  function automatic void model_step(bit r, bit [7:0] req, bit [7:0] mask, bit [2:0] code,
                                     bit ack, bit eoi);
    bit [7:0] seen;
    bit [7:0] vis;
    bit       take;
    if (!r) begin
      model_reset();
      return;
    end
    if (Lat == 0) seen = req;
    else begin
      seen = m_dly.pop_front();
      m_dly.push_back(req);
    end
    vis  = m_latched & ~mask;
    take = (m_mode == ModeReq) && ack && vis[code];
    if (m_mode == ModeIdle && vis != 0) m_mode = ModeReq;
    else if (m_mode == ModeReq && vis == 0) m_mode = ModeIdle;
    else if (take) m_mode = ModeService;
    else if (m_mode == ModeService && eoi) m_mode = ModeIdle;
    if (take) begin
      m_latched[code] = 1'b0;
      m_isr           = code;
    end
    m_latched = m_latched | (seen & ~m_prev);
    m_prev    = seen;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(bit r, bit [7:0] req, bit [7:0] mask, bit [2:0] code, bit ack, bit eoi);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    bus.req  = req;
    bus.mask = mask;
    bus.code = code;
    bus.ack  = ack;
    bus.eoi  = eoi;
    model_step(r, req, mask, code, ack, eoi);
    @(posedge clk);
    e.pend = m_latched & ~mask;
    e.irq  = (m_mode == ModeReq);
    e.busy = (m_mode == ModeService);
    e.isr  = m_isr;
    sb_q.push_back(e);
  endtask

  // Monitor: every output sample after an edge is checked against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_pend", 32'(bus.pend), 32'(e.pend));
        chk("sb_irq", 32'(bus.irq), 32'(e.irq));
        chk("sb_busy", 32'(bus.busy), 32'(e.busy));
        chk("sb_isr_idx", 32'(bus.isr_idx), 32'(e.isr));
      end
    end
  end

  initial begin
    bit [7:0] rq;
    bit [7:0] mk;
    bit [2:0] cd;
    bus.req  = '0;
    bus.mask = '0;
    bus.code = '0;
    bus.ack  = 1'b0;
    bus.eoi  = 1'b0;
    model_reset();

    // Single event
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0);
    #1 chk("reset_pend", 32'(bus.pend), 0);
    chk("reset_irq", 32'(bus.irq), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    cycle(1, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h08, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < Lat; i++) cycle(1, 8'h08, 8'h00, 3'd0, 0, 0);
    #1 chk("single_pend", 32'(bus.pend), 32'h08);
    chk("single_irq_early", 32'(bus.irq), 0);
    cycle(1, 8'h08, 8'h00, 3'd0, 0, 0);
    #1 chk("single_irq", 32'(bus.irq), 1);
    cycle(1, 8'h08, 8'h00, 3'd3, 1, 0);
    #1 chk("single_isr", 32'(bus.isr_idx), 3);
    chk("single_busy", 32'(bus.busy), 1);
    chk("single_pend_clr", 32'(bus.pend), 0);
    cycle(1, 8'h08, 8'h00, 3'd0, 0, 1);
    #1 chk("single_eoi_busy", 32'(bus.busy), 0);
    chk("single_eoi_irq", 32'(bus.irq), 0);

    // Mask path
    cycle(0, 8'h00, 8'h80, 3'd0, 0, 0);
    cycle(1, 8'h00, 8'h80, 3'd0, 0, 0);
    cycle(1, 8'h81, 8'h80, 3'd0, 0, 0);
    for (int i = 0; i < Lat; i++) cycle(1, 8'h81, 8'h80, 3'd0, 0, 0);
    #1 chk("mask_pend", 32'(bus.pend), 32'h01);
    cycle(1, 8'h81, 8'h80, 3'd0, 0, 0);
    #1 chk("mask_irq", 32'(bus.irq), 1);
    cycle(1, 8'h81, 8'hFF, 3'd0, 0, 0);
    #1 chk("mask_irq_drop", 32'(bus.irq), 0);
    cycle(1, 8'h81, 8'h00, 3'd0, 0, 0);
    #1 chk("mask_retained", 32'(bus.pend), 32'h81);

    // Bad ack, then set/clear collision on bit 2
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h04, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < Lat; i++) cycle(1, 8'h04, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h04, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h04, 8'h00, 3'd5, 1, 0);
    #1 chk("badack_irq", 32'(bus.irq), 1);
    chk("badack_busy", 32'(bus.busy), 0);
    chk("badack_isr", 32'(bus.isr_idx), 0);
    for (int i = 0; i < Lat + 1; i++) cycle(1, 8'h00, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < Lat; i++) cycle(1, 8'h04, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h04, 8'h00, 3'd2, 1, 0);
    #1 chk("collide_busy", 32'(bus.busy), 1);
    chk("collide_pend", 32'(bus.pend), 32'h04);
    chk("collide_isr", 32'(bus.isr_idx), 2);

    // Reset mid-service
    cycle(0, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h00, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h31, 8'h00, 3'd0, 0, 0);
    for (int i = 0; i < Lat; i++) cycle(1, 8'h31, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h31, 8'h00, 3'd0, 0, 0);
    cycle(1, 8'h31, 8'h00, 3'd0, 1, 0);
    #1 chk("svc_pend", 32'(bus.pend), 32'h30);
    chk("svc_busy", 32'(bus.busy), 1);
    cycle(0, 8'h01, 8'h00, 3'd4, 1, 1);
    #1 chk("rst_svc_pend", 32'(bus.pend), 0);
    chk("rst_svc_busy", 32'(bus.busy), 0);
    chk("rst_svc_irq", 32'(bus.irq), 0);
    chk("rst_svc_isr", 32'(bus.isr_idx), 0);
    for (int i = 0; i < Lat + 1; i++) cycle(1, 8'h01, 8'h00, 3'd0, 0, 0);
    #1 chk("release_pend", 32'(bus.pend), 32'h01);

    // Random traffic
    rq = 8'h01;
    for (int n = 0; n < 800; n++) begin
      rq = rq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mk = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
      cd = 3'($urandom);
      for (int t = 0; t < 8 && !m_latched[cd]; t++) cd = 3'($urandom);
      cycle(($urandom_range(0, 99) != 0), rq, mk, cd, ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 2));
    end

    repeat (3) @(posedge clk);
    #2 chk("sb_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 The block SHALL have no parameters; the request width is fixed at 8 to match the downstream 8-to-3 priority encoder.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst_n, input, 1: synchronous active-low reset.
REQ-005 Port req, input, 8: raw interrupt lines; a rising edge is an event.
REQ-006 Port mask, input, 8: a 1 blocks that bit from pend but does not block latching.
REQ-007 Port pend, output, 8: pending & ~mask; feeds the priority encoder x input.
REQ-008 Port code, input, 3: encoder y output, the index of the winning request.
REQ-009 Port irq, output, 1: a request is presented; high only in state REQ.
REQ-010 Port ack, input, 1: single-cycle pulse; the consumer accepts code.
REQ-011 Port eoi, input, 1: single-cycle pulse; end of service.
REQ-012 Port busy, output, 1: high only in state SERVICE.
REQ-013 Port isr_idx, output, 3: the index captured at ack; holds until the next capture.

Function
REQ-014 Edge detect SHALL be req & ~req_q, where req_q is req registered every cycle; a detected edge sets the matching pending bit at the same clock edge.
REQ-015 pend SHALL be combinational from the pending register and mask; no other path.
REQ-016 The FSM SHALL have three states:
- IDLE -> REQ at the next edge when pend != 0.
- REQ -> SERVICE on ack when pend[code] = 1.
- SERVICE -> IDLE on eoi.
REQ-017 On an accepted ack, the block SHALL at the same edge clear pending[code], load isr_idx = code, deassert irq, and assert busy.
REQ-018 In REQ, ack with pend[code] = 0 SHALL be ignored; the state stays REQ.
REQ-019 In REQ, if pend becomes 0 (mask change), the FSM SHALL return to IDLE at the next edge and deassert irq; pending bits are retained.
REQ-020 ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-021 When an edge on bit i coincides with a clear of bit i, set SHALL win; the bit stays pending.
REQ-022 Edges SHALL continue latching in all states; a repeated edge on an already-pending bit is absorbed (no count).
REQ-023 Latency without sync: req rises before edge k, so pend is valid after edge k and irq is high after edge k+1.

Reset
REQ-024 With rst_n = 0 at a clock edge, the following SHALL be cleared:
- pending = 0, req_q = 0, and any synchronizer flops = 0.
- State = IDLE, so irq = 0, busy = 0, isr_idx = 0.
REQ-025 Reset SHALL override ack, eoi and edges in the same cycle, including mid-SERVICE.
REQ-026 A line held high through reset release SHALL produce exactly one event on the first edge after release.

Configuration
REQ-027 Macro IRQ_LATCH_SYNC_EN selects input synchronization:
- Defined: req passes through a 2-flop synchronizer before edge detect, and every latency in REQ-023 grows by 2 cycles.
- Undefined: req feeds edge detect directly.

Verification
REQ-028 Single event: req = 8'h08 from 0 -> pend = 8'h08 after edge k and irq = 1 after k+1; then code = 3, ack -> isr_idx = 3, busy = 1, pend = 0; then eoi -> IDLE.
REQ-029 Mask path:
- pending = 8'h81 with mask = 8'h80 -> pend = 8'h01.
- Then mask = 8'hFF while in REQ -> irq drops next edge; pending remains 8'h81.
REQ-030 Bad ack: pend = 8'h04 and code = 5 with ack -> state REQ, irq = 1, isr_idx unchanged.
REQ-031 Collision: bit 2 pending; ack with code = 2 in the same cycle as a new rising edge on req[2] -> pending[2] = 1 and state = SERVICE.
REQ-032 Reset mid-service:
- In SERVICE with pending = 8'h30, rst_n = 0 for one edge -> all outputs 0 and state IDLE.
- With req held at 8'h01 -> pend = 8'h01 after the first edge after release.
REQ-033 With IRQ_LATCH_SYNC_EN defined, rerun REQ-028 -> pend after edge k+2 and irq after edge k+3.
